// File: rtl/lsu_misalign_split.sv
// Misaligned-access engine for the LSU address-check stage: issues aligned accesses as one beat,
// splits bus-word-straddling accesses into two aligned beats, and traps what cannot be split.
module lsu_misalign_split #(
  parameter int unsigned XLEN                  = 64,
  parameter int unsigned VIRTUAL_ADDR_LEN      = 39,
  parameter int unsigned PAGE_OFFSET_W         = 12,
  parameter int unsigned EXCEPTION_CAUSE_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             split_en_i,
  input  logic                             flush_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic                             req_ls_i,
  input  logic [1:0]                       req_size_i,
  input  logic                             req_signed_i,
  input  logic                             req_amo_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]      req_addr_i,
  input  logic [XLEN-1:0]                  req_wdata_i,
  output logic                             mem_req_valid_o,
  input  logic                             mem_req_ready_i,
  output logic                             mem_req_we_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]      mem_req_addr_o,
  output logic [XLEN/8-1:0]                mem_req_wmask_o,
  output logic [XLEN-1:0]                  mem_req_wdata_o,
  input  logic                             mem_resp_valid_i,
  input  logic [XLEN-1:0]                  mem_resp_rdata_i,
  output logic                             resp_valid_o,
  output logic [XLEN-1:0]                  resp_rdata_o,
  output logic                             resp_exception_o,
  output logic [EXCEPTION_CAUSE_WIDTH-1:0] resp_ecause_o
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned VA   = VIRTUAL_ADDR_LEN;

  localparam logic [EXCEPTION_CAUSE_WIDTH-1:0] CauseLoadMisaligned  = EXCEPTION_CAUSE_WIDTH'(4);
  localparam logic [EXCEPTION_CAUSE_WIDTH-1:0] CauseStoreMisaligned = EXCEPTION_CAUSE_WIDTH'(6);

  typedef enum logic [2:0] {
    StIdle,
    StIssue0,
    StWait0,
    StIssue1,
    StWait1,
    StResp,
    StDrain
  } state_e;

  state_e            state_q;
  logic              ls_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [OFFW-1:0]   off_q;
  logic              cross_q;
  logic [VA-1:0]     beat1_addr_q;
  logic [NB-1:0]     beat1_mask_q;
  logic [XLEN-1:0]   beat1_data_q;
  logic [XLEN-1:0]   rdata0_q;
  logic              resp_valid_q;

  logic [OFFW-1:0]   req_off;
  logic [3:0]        req_bytes;
  logic [NB-1:0]     req_mask_base;
  logic              req_misaligned;
  logic              req_illegal;
  logic              req_cross;
  logic              req_page_cross;
  logic              req_trap;
  logic [VA-1:0]     req_beat0;
  logic [VA-1:0]     req_beat1;
  logic [2*XLEN-1:0] req_data_wide;
  logic [2*NB-1:0]   req_mask_wide;

  // Shift the two-beat window down to the access offset, truncate to size, then extend.
  function automatic logic [XLEN-1:0] merge_load(input logic [XLEN-1:0] r1,
                                                 input logic [XLEN-1:0] r0,
                                                 input logic [OFFW-1:0] off,
                                                 input logic [1:0]      size,
                                                 input logic            sgn);
    logic [XLEN-1:0] w;
    logic [63:0]     e;
    w = XLEN'({r1, r0} >> {off, 3'b000});
    case (size)
      2'd0:    e = {{56{sgn & w[7]}}, w[7:0]};
      2'd1:    e = {{48{sgn & w[15]}}, w[15:0]};
      2'd2:    e = {{32{sgn & w[31]}}, w[31:0]};
      default: e = 64'(w);
    endcase
    return e[XLEN-1:0];
  endfunction

  always_comb begin
    req_off        = req_addr_i[OFFW-1:0];
    req_bytes      = 4'd1 << req_size_i;
    req_mask_base  = NB'((16'd1 << req_bytes) - 16'd1);
    req_misaligned = (req_addr_i[3:0] & (req_bytes - 4'd1)) != 4'd0;
    req_illegal    = (XLEN == 32) && (req_size_i == 2'd3);
    req_cross      = (32'(req_off) + 32'(req_bytes)) > NB;
    req_beat0      = {req_addr_i[VA-1:OFFW], {OFFW{1'b0}}};
    req_beat1      = req_beat0 + VA'(NB);
    req_page_cross = req_cross &&
                     (req_beat1[VA-1:PAGE_OFFSET_W] != req_beat0[VA-1:PAGE_OFFSET_W]);
    req_trap       = req_illegal ||
                     (req_misaligned && (req_amo_i || !split_en_i || req_page_cross));
    req_data_wide  = {{XLEN{1'b0}}, req_wdata_i} << {req_off, 3'b000};
    req_mask_wide  = {{NB{1'b0}}, req_mask_base} << req_off;
  end

  // A flush in the RESP cycle kills the completion pulse.
  assign resp_valid_o = resp_valid_q && !flush_i;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= StIdle;
      req_ready_o      <= 1'b1;
      mem_req_valid_o  <= 1'b0;
      mem_req_we_o     <= 1'b0;
      mem_req_addr_o   <= '0;
      mem_req_wmask_o  <= '0;
      mem_req_wdata_o  <= '0;
      resp_valid_q     <= 1'b0;
      resp_rdata_o     <= '0;
      resp_exception_o <= 1'b0;
      resp_ecause_o    <= '0;
      ls_q             <= 1'b0;
      size_q           <= '0;
      sgn_q            <= 1'b0;
      off_q            <= '0;
      cross_q          <= 1'b0;
      beat1_addr_q     <= '0;
      beat1_mask_q     <= '0;
      beat1_data_q     <= '0;
      rdata0_q         <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i && !flush_i) begin
            req_ready_o  <= 1'b0;
            ls_q         <= req_ls_i;
            size_q       <= req_size_i;
            sgn_q        <= req_signed_i;
            off_q        <= req_off;
            cross_q      <= req_cross;
            beat1_addr_q <= req_beat1;
            beat1_mask_q <= req_mask_wide[2*NB-1:NB];
            beat1_data_q <= req_ls_i ? req_data_wide[2*XLEN-1:XLEN] : '0;
            if (req_trap) begin
              state_q          <= StResp;
              resp_valid_q     <= 1'b1;
              resp_rdata_o     <= '0;
              resp_exception_o <= 1'b1;
              resp_ecause_o    <= req_ls_i ? CauseStoreMisaligned : CauseLoadMisaligned;
            end else begin
              state_q         <= StIssue0;
              mem_req_valid_o <= 1'b1;
              mem_req_we_o    <= req_ls_i;
              mem_req_addr_o  <= req_beat0;
              mem_req_wmask_o <= req_mask_wide[NB-1:0];
              mem_req_wdata_o <= req_ls_i ? req_data_wide[XLEN-1:0] : '0;
            end
          end
        end
        StIssue0, StIssue1: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            if (flush_i)                  state_q <= StDrain;
            else if (state_q == StIssue0) state_q <= StWait0;
            else                          state_q <= StWait1;
          end else if (flush_i) begin
            mem_req_valid_o <= 1'b0;
            req_ready_o     <= 1'b1;
            state_q         <= StIdle;
          end
        end
        StWait0: begin
          if (mem_resp_valid_i) begin
            if (flush_i) begin
              // The outstanding response lands with the flush: nothing left to drain.
              req_ready_o <= 1'b1;
              state_q     <= StIdle;
            end else if (cross_q) begin
              rdata0_q        <= mem_resp_rdata_i;
              state_q         <= StIssue1;
              mem_req_valid_o <= 1'b1;
              mem_req_addr_o  <= beat1_addr_q;
              mem_req_wmask_o <= beat1_mask_q;
              mem_req_wdata_o <= beat1_data_q;
            end else begin
              state_q          <= StResp;
              resp_valid_q     <= 1'b1;
              resp_exception_o <= 1'b0;
              resp_ecause_o    <= '0;
              resp_rdata_o     <= ls_q ? '0
                                       : merge_load('0, mem_resp_rdata_i, off_q, size_q, sgn_q);
            end
          end else if (flush_i) begin
            state_q <= StDrain;
          end
        end
        StWait1: begin
          if (mem_resp_valid_i) begin
            if (flush_i) begin
              req_ready_o <= 1'b1;
              state_q     <= StIdle;
            end else begin
              state_q          <= StResp;
              resp_valid_q     <= 1'b1;
              resp_exception_o <= 1'b0;
              resp_ecause_o    <= '0;
              resp_rdata_o     <= ls_q ? '0
                                       : merge_load(mem_resp_rdata_i, rdata0_q, off_q, size_q,
                                                    sgn_q);
            end
          end else if (flush_i) begin
            state_q <= StDrain;
          end
        end
        StResp: begin
          resp_valid_q     <= 1'b0;
          resp_rdata_o     <= '0;
          resp_exception_o <= 1'b0;
          resp_ecause_o    <= '0;
          req_ready_o      <= 1'b1;
          state_q          <= StIdle;
        end
        StDrain: begin
          if (mem_resp_valid_i) begin
            req_ready_o <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          req_ready_o     <= 1'b1;
          mem_req_valid_o <= 1'b0;
          resp_valid_q    <= 1'b0;
          state_q         <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_misalign_split.sv
// Directed bench for lsu_misalign_split (XLEN=64): single-beat, split, trap, flush and reset cases.
module tb_lsu_misalign_split;

  localparam int unsigned XLEN = 64;
  localparam int unsigned VAL  = 39;

  logic            clk = 1'b0;
  logic            rstn;
  logic            split_en_i;
  logic            flush_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_ls_i;
  logic [1:0]      req_size_i;
  logic            req_signed_i;
  logic            req_amo_i;
  logic [VAL-1:0]  req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic            mem_req_we_o;
  logic [VAL-1:0]  mem_req_addr_o;
  logic [7:0]      mem_req_wmask_o;
  logic [XLEN-1:0] mem_req_wdata_o;
  logic            mem_resp_valid_i;
  logic [XLEN-1:0] mem_resp_rdata_i;
  logic            resp_valid_o;
  logic [XLEN-1:0] resp_rdata_o;
  logic            resp_exception_o;
  logic [4:0]      resp_ecause_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_misalign_split #(
    .XLEN                 (XLEN),
    .VIRTUAL_ADDR_LEN     (VAL),
    .PAGE_OFFSET_W        (12),
    .EXCEPTION_CAUSE_WIDTH(5)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .split_en_i      (split_en_i),
    .flush_i         (flush_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_ls_i        (req_ls_i),
    .req_size_i      (req_size_i),
    .req_signed_i    (req_signed_i),
    .req_amo_i       (req_amo_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_we_o    (mem_req_we_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wmask_o (mem_req_wmask_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_rdata_i(mem_resp_rdata_i),
    .resp_valid_o    (resp_valid_o),
    .resp_rdata_o    (resp_rdata_o),
    .resp_exception_o(resp_exception_o),
    .resp_ecause_o   (resp_ecause_o)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called right after a negedge; presents the request for one posedge (cycle T).
  task automatic issue(input logic ls, input logic [1:0] size, input logic sgn, input logic amo,
                       input logic [VAL-1:0] addr, input logic [XLEN-1:0] wdata);
    check_eq("ready_before_accept", req_ready_o, 1'b1);
    req_valid_i  = 1'b1;
    req_ls_i     = ls;
    req_size_i   = size;
    req_signed_i = sgn;
    req_amo_i    = amo;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    @(negedge clk);
    req_valid_i  = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [VAL-1:0] addr, input logic [7:0] mask,
                             input logic we, input logic [XLEN-1:0] data);
    check_eq({tag, "_valid"}, mem_req_valid_o, 1'b1);
    check_eq({tag, "_addr"}, mem_req_addr_o, addr);
    check_eq({tag, "_mask"}, mem_req_wmask_o, mask);
    check_eq({tag, "_we"}, mem_req_we_o, we);
    if (we) check_eq({tag, "_wdata"}, mem_req_wdata_o, data);
    @(negedge clk);
    check_eq({tag, "_valid_drop"}, mem_req_valid_o, 1'b0);
  endtask

  task automatic give_resp(input logic [XLEN-1:0] rdata);
    mem_resp_valid_i = 1'b1;
    mem_resp_rdata_i = rdata;
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    mem_resp_rdata_i = '0;
  endtask

  task automatic expect_resp(input string tag, input logic [XLEN-1:0] rdata, input logic exc,
                             input logic [4:0] cause);
    check_eq({tag, "_resp_valid"}, resp_valid_o, 1'b1);
    check_eq({tag, "_rdata"}, resp_rdata_o, rdata);
    check_eq({tag, "_exc"}, resp_exception_o, exc);
    if (exc) check_eq({tag, "_cause"}, resp_ecause_o, cause);
    @(negedge clk);
    check_eq({tag, "_resp_pulse"}, resp_valid_o, 1'b0);
    check_eq({tag, "_ready_back"}, req_ready_o, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; split_en_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_ls_i = 1'b0;
    req_size_i = '0; req_signed_i = 1'b0; req_amo_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    mem_req_ready_i = 1'b1; mem_resp_valid_i = 1'b0; mem_resp_rdata_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", req_ready_o, 1'b1);
    check_eq("rst_mem_valid", mem_req_valid_o, 1'b0);
    check_eq("rst_resp_valid", resp_valid_o, 1'b0);
    check_eq("rst_exc", resp_exception_o, 1'b0);
    check_eq("rst_mask", mem_req_wmask_o, 8'h00);
    rstn = 1'b1;

    // Signed word load, one beat.
    issue(1'b0, 2'd2, 1'b1, 1'b0, 39'h1004, '0);
    expect_beat("lw", 39'h1000, 8'hF0, 1'b0, '0);
    give_resp(64'h80000000_00000000);
    expect_resp("lw", 64'hFFFFFFFF_80000000, 1'b0, 5'd0);

    // Unsigned half, misaligned but inside one word.
    issue(1'b0, 2'd1, 1'b0, 1'b0, 39'h1003, '0);
    expect_beat("lhu", 39'h1000, 8'h18, 1'b0, '0);
    give_resp(64'h01234567_89ABCDEF);
    expect_resp("lhu", 64'h6789, 1'b0, 5'd0);

    // Signed byte.
    issue(1'b0, 2'd0, 1'b1, 1'b0, 39'h1002, '0);
    expect_beat("lb", 39'h1000, 8'h04, 1'b0, '0);
    give_resp(64'h01234567_89ABCDEF);
    expect_resp("lb", 64'hFFFFFFFF_FFFFFFAB, 1'b0, 5'd0);

    // Page-crossing double: trap, no traffic.
    issue(1'b0, 2'd3, 1'b0, 1'b0, 39'h1FFD, '0);
    check_eq("pgx_no_beat", mem_req_valid_o, 1'b0);
    expect_resp("pgx", '0, 1'b1, 5'd4);

    // Split double load within a page.
    issue(1'b0, 2'd3, 1'b0, 1'b0, 39'h1005, '0);
    expect_beat("ld_b0", 39'h1000, 8'hE0, 1'b0, '0);
    give_resp(64'hAABBCCDD_EEFF0011);
    expect_beat("ld_b1", 39'h1008, 8'h1F, 1'b0, '0);
    give_resp(64'h11223344_55667788);
    expect_resp("ld_split", 64'h44556677_88AABBCC, 1'b0, 5'd0);

    // Split half store.
    issue(1'b1, 2'd1, 1'b0, 1'b0, 39'h1007, 64'hBEEF);
    expect_beat("sh_b0", 39'h1000, 8'h80, 1'b1, 64'hEF000000_00000000);
    give_resp('0);
    expect_beat("sh_b1", 39'h1008, 8'h01, 1'b1, 64'h00000000_000000BE);
    give_resp('0);
    expect_resp("sh_split", '0, 1'b0, 5'd0);

    // Misaligned AMO store: trap cause 6.
    issue(1'b1, 2'd2, 1'b0, 1'b1, 39'h1002, 64'h1234);
    check_eq("amo_no_beat", mem_req_valid_o, 1'b0);
    expect_resp("amo", '0, 1'b1, 5'd6);

    // Split disabled: misaligned load traps cause 4.
    split_en_i = 1'b0;
    issue(1'b0, 2'd1, 1'b0, 1'b0, 39'h1001, '0);
    check_eq("nosplit_no_beat", mem_req_valid_o, 1'b0);
    expect_resp("nosplit", '0, 1'b1, 5'd4);
    split_en_i = 1'b1;

    // Flush while beat0 is still waiting for ready: straight back to idle.
    mem_req_ready_i = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 1'b0, 39'h2000, '0);
    check_eq("fiss_valid", mem_req_valid_o, 1'b1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    mem_req_ready_i = 1'b1;
    check_eq("fiss_valid_drop", mem_req_valid_o, 1'b0);
    check_eq("fiss_ready", req_ready_o, 1'b1);
    check_eq("fiss_no_resp", resp_valid_o, 1'b0);

    // Flush in WAIT0 of a split load: drain, no beat1, no completion.
    issue(1'b0, 2'd3, 1'b0, 1'b0, 39'h1005, '0);
    expect_beat("fw_b0", 39'h1000, 8'hE0, 1'b0, '0);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check_eq("fw_drain_ready", req_ready_o, 1'b0);
    give_resp(64'hDEADBEEF_DEADBEEF);
    check_eq("fw_ready_after", req_ready_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq("fw_no_beat1", mem_req_valid_o, 1'b0);
      check_eq("fw_no_resp", resp_valid_o, 1'b0);
      @(negedge clk);
    end

    // Reset while waiting for beat1's response; late response must be ignored.
    issue(1'b0, 2'd3, 1'b0, 1'b0, 39'h1005, '0);
    expect_beat("rw_b0", 39'h1000, 8'hE0, 1'b0, '0);
    give_resp(64'h1);
    expect_beat("rw_b1", 39'h1008, 8'h1F, 1'b0, '0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_eq("rw_ready", req_ready_o, 1'b1);
    check_eq("rw_mem_valid", mem_req_valid_o, 1'b0);
    check_eq("rw_addr", mem_req_addr_o, 39'h0);
    check_eq("rw_resp_valid", resp_valid_o, 1'b0);
    check_eq("rw_rdata", resp_rdata_o, 64'h0);
    give_resp(64'h2);
    for (int i = 0; i < 2; i++) begin
      check_eq("rw_late_no_resp", resp_valid_o, 1'b0);
      check_eq("rw_late_ready", req_ready_o, 1'b1);
      @(negedge clk);
    end

    // Engine still works after the reset.
    issue(1'b0, 2'd2, 1'b1, 1'b0, 39'h1004, '0);
    expect_beat("post_lw", 39'h1000, 8'hF0, 1'b0, '0);
    give_resp(64'h7FFFFFFF_00000000);
    expect_resp("post_lw", 64'h00000000_7FFFFFFF, 1'b0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_misalign_split.md
# lsu_misalign_split

Misaligned-access handler for the LSU address-check stage. It replaces the trap-only misalignment check with a parametrised engine. An access that fits in one bus word issues as a single aligned beat. An access that straddles a bus-word boundary is split into two aligned beats, and load data is merged. Accesses that cannot be split (atomics, page-crossing, or split disabled) raise the misaligned exception with no memory traffic. It sits between the AGU/AC stage and the D-cache request port.

## Interface
- XLEN, 64: data/bus width in bits (32 or 64); bus word = XLEN/8 bytes.
- VIRTUAL_ADDR_LEN, 39: address width.
- PAGE_OFFSET_W, 12: page-offset bits; a split whose second beat changes addr[VIRTUAL_ADDR_LEN-1:PAGE_OFFSET_W] is page-crossing.
- EXCEPTION_CAUSE_WIDTH, 5: cause width.
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- split_en_i  in  1  1 = split misaligned, 0 = trap all misaligned.
- flush_i  in  1  kill in-flight request.
- req_valid_i / req_ready_o  in/out  1  request handshake.
- req_ls_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  0 B, 1 H, 2 W, 3 D (3 illegal when XLEN=32: treated as misaligned trap).
- req_signed_i  in  1  sign-extend load result.
- req_amo_i  in  1  AMO/LR/SC; never split.
- req_addr_i  in  VIRTUAL_ADDR_LEN  byte address.
- req_wdata_i  in  XLEN  store data, LSB-justified.
- mem_req_valid_o / mem_req_ready_i  out/in  1  memory handshake.
- mem_req_we_o  out  1  write.
- mem_req_addr_o  out  VIRTUAL_ADDR_LEN  bus-word-aligned address.
- mem_req_wmask_o  out  XLEN/8  byte strobes.
- mem_req_wdata_o  out  XLEN  lane-positioned data.
- mem_resp_valid_i  in  1  one response per accepted beat, in order; always accepted.
- mem_resp_rdata_i  in  XLEN  load data.
- resp_valid_o  out  1  single-cycle completion pulse (no backpressure).
- resp_rdata_o  out  XLEN  extended load result (0 for stores).
- resp_exception_o  out  1  exception flag.
- resp_ecause_o  out  EXCEPTION_CAUSE_WIDTH  4 load-misaligned, 6 store-misaligned.

## Operation
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP, DRAIN.
- Reset: state IDLE. All outputs 0, except req_ready_o=1.
- req_ready_o=1 only in IDLE. On accept, latch all request fields. Compute off = addr mod (XLEN/8) and bytes = 1<<size.
- Misaligned means addr mod bytes != 0. Crossing means off+bytes > XLEN/8.
- Trap if misaligned and any of the following: req_amo_i, !split_en_i, page-crossing, or illegal size. Trap path: IDLE -> RESP with exception=1 and cause per req_ls_i; no mem beat.
- Aligned, or misaligned but not crossing: IDLE -> ISSUE0 -> WAIT0 -> RESP (one beat).
- Crossing: ISSUE0 -> WAIT0 -> ISSUE1 -> WAIT1 -> RESP.
- Beat0: addr & ~(XLEN/8-1). Beat1: beat0 + XLEN/8. Within 2*XLEN bits, {data1, data0} = wdata << 8*off and {mask1, mask0} = ((1<<bytes)-1) << off.
- Load merge: ({rdata1, rdata0} >> 8*off), truncated to bytes, then sign- or zero-extended to XLEN. Single beat uses rdata0 only.
- ISSUEx: mem_req_valid_o=1 with stable fields until mem_req_ready_i; then -> WAITx.
- WAITx: on mem_resp_valid_i, capture rdata; WAIT0 -> ISSUE1 or RESP, WAIT1 -> RESP.
- RESP: resp_valid_o=1 for one cycle, then -> IDLE.
- flush_i behaviour by state:
  - ISSUE0 or ISSUE1 with no handshake in the same cycle: -> IDLE.
  - ISSUEx with a handshake that same cycle, or in WAITx: -> DRAIN.
  - RESP: suppress resp_valid_o and go -> IDLE.
  - IDLE: also blocks acceptance that cycle.
- DRAIN: swallow the one outstanding response, then -> IDLE. A split whose beat0 is flushed never issues beat1.
- Stores are split non-atomically; beat0 is committed even if beat1 later faults externally.

## Timing
- Accept at cycle T. mem_req_valid_o rises at T+1.
- Trap: resp_valid_o at T+1.
- Single beat with mem ready and resp each in 1 cycle: handshake T+1, resp T+2, resp_valid_o T+3.
- Split under the same conditions: beat1 issued T+3, resp T+4, resp_valid_o T+5.
- Next accept is possible the cycle after RESP.
- mem_resp_valid_i outside WAITx/DRAIN is a protocol error and is ignored.
- rstn low has priority over flush and handshakes. Outstanding responses arriving after reset are ignored (IDLE).

## Test plan
- Load W at 0x1004, XLEN=64, signed, rdata0=0x80000000_00000000 -> one beat at addr 0x1000, resp_rdata=0xFFFFFFFF_80000000, resp at T+3.
- Load D at 0x1FFD, split_en=1, rdata0=0xAABBCCDD_EEFF0011 and rdata1=0x1122334455667788 -> beats at 0x1FF8/0x2000, but page-crossing at 0x2000 boundary, so instead expect exception cause 4, zero beats. Repeat at 0x1005 -> beats 0x1000/0x1008, result = {rdata1[39:0], rdata0[63:40]}.
- Store H at 0x1007, wdata=0xBEEF -> beat0 mask 0x80 with data byte7=0xEF; beat1 mask 0x01 with byte0=0xBE; resp exception=0.
- AMO W at 0x1002 -> resp at T+1, cause 6, mem_req_valid never asserted. Same with split_en=0 on a plain load H at 0x1001 -> cause 4.
- Flush in WAIT0 of a split load -> DRAIN, response swallowed, no beat1, no resp_valid_o, req_ready_o back after drain.
- Reset asserted in WAIT1 -> next cycle all outputs 0, req_ready_o=1; a late mem_resp_valid_i produces no resp.
